// File: rtl/addsub_pkg.sv
// addsub_pkg: operation encodings and first-stage carry selection shared by addsub_pipe.
package addsub_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

    // Subtraction is a + ~b + 1, so borrow-in inverts the incoming carry.
    function automatic logic calc_c0(input logic [1:0] op, input logic cin);
        logic c0;
        case (op)
            OP_ADD:  c0 = 1'b0;
            OP_SUB:  c0 = 1'b1;
            OP_ADC:  c0 = cin;
            default: c0 = ~cin;
        endcase
        return c0;
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// addsub_seg: combinational SEG-bit adder slice with carry in and carry out.
module addsub_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: segmented pipelined add/sub (one SEG-bit slice per stage) with valid/ready flow.
// Optional signed saturation is built only when ADDSUB_SAT_EN is defined.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int W   = 32,
    parameter int SEG = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [1:0]   in_op,
    input  logic         in_cin,
    input  logic         in_sat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_s,
    output logic         out_cf,
    output logic         out_of,
    output logic         out_zf,
    output logic         out_nf
);

    localparam int NSEG = W / SEG;
    localparam int LAST = NSEG - 1;
    localparam logic [W-1:0] SEG_MASK = W'({SEG{1'b1}});

    logic advance;

    // Per-stage registers: index k holds the beat after stage k has summed its slice.
    logic [W-1:0] a_reg   [NSEG];
    logic [W-1:0] bb_reg  [NSEG];
    logic [W-1:0] s_reg   [NSEG];
    logic         c_reg   [NSEG];
    logic         op0_reg [NSEG];
    logic         vld_reg [NSEG];

    // Values entering stage k (from the ports for k = 0, else from stage k-1).
    logic [W-1:0] cur_a   [NSEG];
    logic [W-1:0] cur_bb  [NSEG];
    logic [W-1:0] cur_s   [NSEG];
    logic         cur_c   [NSEG];
    logic         cur_op0 [NSEG];
    logic         cur_vld [NSEG];
    logic [W-1:0] nxt_s   [NSEG];
    logic         nxt_c   [NSEG];

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
        logic [SEG-1:0] seg_s;
        logic           seg_co;

        if (gi == 0) begin : g_first
            assign cur_a[gi]   = in_a;
            assign cur_bb[gi]  = in_b ^ {W{in_op[0]}};
            assign cur_s[gi]   = '0;
            assign cur_c[gi]   = calc_c0(in_op, in_cin);
            assign cur_op0[gi] = in_op[0];
            assign cur_vld[gi] = in_valid;
        end else begin : g_next
            assign cur_a[gi]   = a_reg[gi-1];
            assign cur_bb[gi]  = bb_reg[gi-1];
            assign cur_s[gi]   = s_reg[gi-1];
            assign cur_c[gi]   = c_reg[gi-1];
            assign cur_op0[gi] = op0_reg[gi-1];
            assign cur_vld[gi] = vld_reg[gi-1];
        end

        addsub_seg #(.SEG(SEG)) u_seg (
            .a  (cur_a[gi][gi*SEG +: SEG]),
            .b  (cur_bb[gi][gi*SEG +: SEG]),
            .ci (cur_c[gi]),
            .s  (seg_s),
            .co (seg_co)
        );

        assign nxt_s[gi] = (cur_s[gi] & ~(SEG_MASK << (gi*SEG))) | (W'(seg_s) << (gi*SEG));
        assign nxt_c[gi] = seg_co;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSEG; k++) begin
                vld_reg[k] <= 1'b0;
                a_reg[k]   <= '0;
                bb_reg[k]  <= '0;
                s_reg[k]   <= '0;
                c_reg[k]   <= 1'b0;
                op0_reg[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < NSEG; k++) begin
                vld_reg[k] <= cur_vld[k];
                a_reg[k]   <= cur_a[k];
                bb_reg[k]  <= cur_bb[k];
                s_reg[k]   <= nxt_s[k];
                c_reg[k]   <= nxt_c[k];
                op0_reg[k] <= cur_op0[k];
            end
        end
    end

    logic         a_msb;
    logic         bb_msb;
    logic [W-1:0] s_raw;

    assign a_msb     = a_reg[LAST][W-1];
    assign bb_msb    = bb_reg[LAST][W-1];
    assign s_raw     = s_reg[LAST];
    assign out_valid = vld_reg[LAST];
    assign out_cf    = c_reg[LAST] ^ op0_reg[LAST];
    assign out_of    = (~a_msb & ~bb_msb & s_raw[W-1]) | (a_msb & bb_msb & ~s_raw[W-1]);

`ifdef ADDSUB_SAT_EN
    logic sat_reg [NSEG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSEG; k++) begin
                sat_reg[k] <= 1'b0;
            end
        end else if (advance) begin
            sat_reg[0] <= in_sat;
            for (int k = 1; k < NSEG; k++) begin
                sat_reg[k] <= sat_reg[k-1];
            end
        end
    end

    // Overflow direction follows the sign of a: both operands share it when overflow occurs.
    assign out_s = (sat_reg[LAST] & out_of) ? (a_msb ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                                            : s_raw;
`else
    logic sat_unused;
    assign sat_unused = in_sat;
    assign out_s      = s_raw;
`endif

    // Zero flag qualified by valid so the idle/reset state reports all flags low.
    assign out_zf = out_valid & (out_s == '0);
    assign out_nf = out_s[W-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: self-checking bench for addsub_pipe at W/SEG = 32/8, 16/16 and 64/8.
// Honours ADDSUB_SAT_EN when the design is built with saturation.
module tb_addsub_pipe;

`ifdef ADDSUB_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [63:0] s;
        logic        cf;
        logic        of;
        logic        zf;
        logic        nf;
    } res_t;

    typedef struct {
        res_t r;
        int   cyc;
    } exp_t;

    // Reference: exact integer arithmetic, unsigned for carry/borrow, signed for overflow.
    function automatic res_t model(int w, logic [63:0] a, logic [63:0] b, logic [1:0] op,
                                   logic cin, logic sat);
        res_t r;
        logic [63:0] mask;
        logic signed [67:0] ua, ub, sa, sb, ci, res_u, res_s, maxp, minn;
        mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        ua    = $signed({4'b0, a & mask});
        ub    = $signed({4'b0, b & mask});
        sa    = a[w-1] ? ua - (68'sd1 <<< w) : ua;
        sb    = b[w-1] ? ub - (68'sd1 <<< w) : ub;
        ci    = (op[1] && cin) ? 68'sd1 : 68'sd0;
        maxp  = (68'sd1 <<< (w-1)) - 68'sd1;
        minn  = -(68'sd1 <<< (w-1));
        if (!op[0]) begin
            res_u = ua + ub + ci;
            res_s = sa + sb + ci;
            r.cf  = (res_u >= (68'sd1 <<< w));
        end else begin
            res_u = ua - ub - ci;
            res_s = sa - sb - ci;
            r.cf  = (res_u < 68'sd0);
        end
        r.of = (res_s > maxp) || (res_s < minn);
        r.s  = res_u[63:0] & mask;
        if (SAT_EN && sat && r.of) r.s = (res_s > maxp) ? maxp[63:0] : (minn[63:0] & mask);
        r.zf = (r.s == 64'd0);
        r.nf = r.s[w-1];
        return r;
    endfunction

    function automatic logic [63:0] rnd_opnd(int w);
        logic [63:0] v, mask;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = 64'd1 << (w-1);
            3:       v = (64'd1 << (w-1)) - 64'd1;
            default: v = {$urandom, $urandom};
        endcase
        return v & mask;
    endfunction

    // DUT instances
    logic        p32_in_valid, p32_in_ready, p32_in_cin, p32_in_sat, p32_out_valid, p32_out_ready;
    logic [31:0] p32_in_a, p32_in_b, p32_out_s;
    logic [1:0]  p32_in_op;
    logic        p32_out_cf, p32_out_of, p32_out_zf, p32_out_nf;

    logic        p16_in_valid, p16_in_ready, p16_in_cin, p16_in_sat, p16_out_valid, p16_out_ready;
    logic [15:0] p16_in_a, p16_in_b, p16_out_s;
    logic [1:0]  p16_in_op;
    logic        p16_out_cf, p16_out_of, p16_out_zf, p16_out_nf;

    logic        p64_in_valid, p64_in_ready, p64_in_cin, p64_in_sat, p64_out_valid, p64_out_ready;
    logic [63:0] p64_in_a, p64_in_b, p64_out_s;
    logic [1:0]  p64_in_op;
    logic        p64_out_cf, p64_out_of, p64_out_zf, p64_out_nf;

    addsub_pipe #(.W(32), .SEG(8)) u_p32 (
        .clk(clk), .rst_n(rst_n), .in_valid(p32_in_valid), .in_ready(p32_in_ready),
        .in_a(p32_in_a), .in_b(p32_in_b), .in_op(p32_in_op), .in_cin(p32_in_cin),
        .in_sat(p32_in_sat), .out_valid(p32_out_valid), .out_ready(p32_out_ready),
        .out_s(p32_out_s), .out_cf(p32_out_cf), .out_of(p32_out_of), .out_zf(p32_out_zf),
        .out_nf(p32_out_nf)
    );

    addsub_pipe #(.W(16), .SEG(16)) u_p16 (
        .clk(clk), .rst_n(rst_n), .in_valid(p16_in_valid), .in_ready(p16_in_ready),
        .in_a(p16_in_a), .in_b(p16_in_b), .in_op(p16_in_op), .in_cin(p16_in_cin),
        .in_sat(p16_in_sat), .out_valid(p16_out_valid), .out_ready(p16_out_ready),
        .out_s(p16_out_s), .out_cf(p16_out_cf), .out_of(p16_out_of), .out_zf(p16_out_zf),
        .out_nf(p16_out_nf)
    );

    addsub_pipe #(.W(64), .SEG(8)) u_p64 (
        .clk(clk), .rst_n(rst_n), .in_valid(p64_in_valid), .in_ready(p64_in_ready),
        .in_a(p64_in_a), .in_b(p64_in_b), .in_op(p64_in_op), .in_cin(p64_in_cin),
        .in_sat(p64_in_sat), .out_valid(p64_out_valid), .out_ready(p64_out_ready),
        .out_s(p64_out_s), .out_cf(p64_out_cf), .out_of(p64_out_of), .out_zf(p64_out_zf),
        .out_nf(p64_out_nf)
    );

    // Drives one beat into the 32-bit unit and waits (bounded) for its result; lat = -1 on timeout.
    task automatic run_beat(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                            input logic cin, input logic sat, output logic [35:0] got, output int lat);
        @(posedge clk); #1;
        p32_in_valid = 1'b1; p32_in_a = a; p32_in_b = b; p32_in_op = op;
        p32_in_cin = cin; p32_in_sat = sat; p32_out_ready = 1'b1;
        lat = -1;
        got = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            p32_in_valid = 1'b0;
            @(negedge clk);
            if (p32_out_valid) begin
                lat = i;
                got = {p32_out_s, p32_out_cf, p32_out_of, p32_out_zf, p32_out_nf};
                break;
            end
        end
        $display("beat a=%h b=%h op=%0d cin=%0d sat=%0d -> s/cf/of/zf/nf=%h lat=%0d",
                 a, b, op, cin, sat, got, lat);
    endtask

    task automatic test_reset;
        p32_in_valid = 0; p32_in_a = '0; p32_in_b = '0; p32_in_op = '0; p32_in_cin = 0; p32_in_sat = 0;
        p16_in_valid = 0; p16_in_a = '0; p16_in_b = '0; p16_in_op = '0; p16_in_cin = 0; p16_in_sat = 0;
        p64_in_valid = 0; p64_in_a = '0; p64_in_b = '0; p64_in_op = '0; p64_in_cin = 0; p64_in_sat = 0;
        p32_out_ready = 0; p16_out_ready = 1; p64_out_ready = 1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({p32_out_valid, p32_out_s, p32_out_cf, p32_out_of, p32_out_zf, p32_out_nf} !== 37'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0",
                     {p32_out_valid, p32_out_s, p32_out_cf, p32_out_of, p32_out_zf, p32_out_nf});
        end
        checks++;
        if ({p16_out_valid, p64_out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_valid_sweep got %b required 00", {p16_out_valid, p64_out_valid});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({p32_in_ready, p16_in_ready, p64_in_ready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_in_ready got %b required 111", {p32_in_ready, p16_in_ready, p64_in_ready});
        end
        $display("reset done: out_valid=%0d in_ready=%0d", p32_out_valid, p32_in_ready);
        p32_out_ready = 1;
    endtask

    task automatic test_directed;
        logic [35:0] got, want;
        int lat;
        run_beat(32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, 1'b0, got, lat);
        checks++;
        want = {32'h0, 1'b1, 1'b0, 1'b1, 1'b0};
        if (got !== want) begin errors++; $display("FAIL add_wrap got %h required %h", got, want); end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL add_latency got %0d required 4", lat); end

        run_beat(32'h8000_0000, 32'h0000_0001, 2'b01, 1'b0, 1'b0, got, lat);
        checks++;
        want = {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        if (got !== want) begin errors++; $display("FAIL sub_ovf got %h required %h", got, want); end

        run_beat(32'h8000_0000, 32'h0000_0001, 2'b01, 1'b0, 1'b1, got, lat);
        checks++;
        want = SAT_EN ? {32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1} : {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        if (got !== want) begin errors++; $display("FAIL sub_sat got %h required %h", got, want); end

        run_beat(32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, 1'b1, got, lat);
        checks++;
        want = SAT_EN ? {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0} : {32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        if (got !== want) begin errors++; $display("FAIL add_sat got %h required %h", got, want); end
    endtask

    task automatic test_multiword;
        logic [35:0] got, want;
        int lat;
        run_beat(32'hFFFF_FFFF, 32'h1, 2'b00, 1'b0, 1'b0, got, lat);
        checks++;
        if (got[3] !== 1'b1) begin errors++; $display("FAIL mw_add_cf got %b required 1", got[3]); end
        run_beat(32'h0, 32'h0, 2'b10, got[3], 1'b0, got, lat);
        checks++;
        want = {32'h1, 1'b0, 1'b0, 1'b0, 1'b0};
        if (got !== want) begin errors++; $display("FAIL mw_adc got %h required %h", got, want); end
        run_beat(32'h0, 32'h0, 2'b11, 1'b1, 1'b0, got, lat);
        checks++;
        want = {32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        if (got !== want) begin errors++; $display("FAIL mw_sbb got %h required %h", got, want); end
    endtask

    task automatic test_backpressure;
        res_t q[$];
        res_t e;
        logic [31:0] a, b;
        logic [1:0]  op;
        logic        cin, sat, pend, held;
        logic [35:0] hold_v, cur_v;
        logic [3:0]  pat;
        int acc, got;
        pat = 4'b1001; pend = 0; held = 0; acc = 0; got = 0;
        a = '0; b = '0; op = '0; cin = 0; sat = 0; hold_v = '0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            @(posedge clk); #1;
            p32_out_ready = pat[cyc % 4];
            if (!pend && acc < 8) begin
                a = rnd_opnd(32); b = rnd_opnd(32);
                op = 2'($urandom_range(0, 3)); cin = 1'($urandom_range(0, 1)); sat = 1'($urandom_range(0, 1));
                p32_in_a = a; p32_in_b = b; p32_in_op = op; p32_in_cin = cin; p32_in_sat = sat;
                p32_in_valid = 1'b1; pend = 1;
            end else if (!pend) begin
                p32_in_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (p32_in_ready !== (~p32_out_valid | p32_out_ready)) begin
                errors++;
                $display("FAIL bp_in_ready got %b required %b", p32_in_ready, ~p32_out_valid | p32_out_ready);
            end
            cur_v = {p32_out_s, p32_out_cf, p32_out_of, p32_out_zf, p32_out_nf};
            if (p32_out_valid) begin
                if (held) begin
                    checks++;
                    if (cur_v !== hold_v) begin errors++; $display("FAIL bp_stable got %h required %h", cur_v, hold_v); end
                end
                if (p32_out_ready) begin
                    held = 0;
                    checks++;
                    if (q.size() == 0) begin
                        errors++; $display("FAIL bp_unexpected got %h required none", cur_v);
                    end else begin
                        e = q.pop_front();
                        if (cur_v !== {e.s[31:0], e.cf, e.of, e.zf, e.nf}) begin
                            errors++;
                            $display("FAIL bp_result got %h required %h", cur_v, {e.s[31:0], e.cf, e.of, e.zf, e.nf});
                        end
                    end
                    $display("bp retire %0d: %h", got, cur_v);
                    got++;
                end else begin
                    held = 1; hold_v = cur_v;
                end
            end
            if (p32_in_valid && p32_in_ready) begin
                q.push_back(model(32, {32'h0, a}, {32'h0, b}, op, cin, sat));
                acc++; pend = 0;
            end
        end
        checks++;
        if (got != 8) begin errors++; $display("FAIL bp_timeout got %0d beats required 8", got); end
        p32_in_valid = 0; p32_out_ready = 1;
    endtask

    task automatic test_async_reset;
        p32_out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            p32_in_valid = 1; p32_in_a = rnd_opnd(32)[31:0]; p32_in_b = rnd_opnd(32)[31:0]; p32_in_op = 2'b00;
        end
        @(posedge clk); #1;
        p32_in_valid = 0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (p32_out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b required 1", p32_out_valid); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({p32_out_valid, p32_out_s, p32_out_cf, p32_out_of, p32_out_zf, p32_out_nf} !== 37'd0) begin
            errors++;
            $display("FAIL arst_clear got %h required 0",
                     {p32_out_valid, p32_out_s, p32_out_cf, p32_out_of, p32_out_zf, p32_out_nf});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (p32_out_valid !== 1'b0) begin errors++; $display("FAIL arst_stale cycle %0d got 1 required 0", i); end
        end
        $display("async reset: pipeline flushed");
    endtask

    task automatic test_back_to_back;
        exp_t q32[$], q16[$], q64[$];
        exp_t e;
        logic [63:0] a, b;
        logic [1:0]  op;
        logic        cin, sat;
        int n;
        n = 10000;
        p32_out_ready = 1; p16_out_ready = 1; p64_out_ready = 1;
        for (int cyc = 0; cyc < n + 20; cyc++) begin
            @(posedge clk); #1;
            if (cyc < n) begin
                a = rnd_opnd(32); b = rnd_opnd(32); op = 2'($urandom_range(0, 3));
                cin = 1'($urandom_range(0, 1)); sat = 1'($urandom_range(0, 1));
                p32_in_valid = 1; p32_in_a = a[31:0]; p32_in_b = b[31:0]; p32_in_op = op; p32_in_cin = cin; p32_in_sat = sat;
                q32.push_back('{model(32, a, b, op, cin, sat), cyc});
                a = rnd_opnd(16); b = rnd_opnd(16); op = 2'($urandom_range(0, 3));
                cin = 1'($urandom_range(0, 1)); sat = 1'($urandom_range(0, 1));
                p16_in_valid = 1; p16_in_a = a[15:0]; p16_in_b = b[15:0]; p16_in_op = op; p16_in_cin = cin; p16_in_sat = sat;
                q16.push_back('{model(16, a, b, op, cin, sat), cyc});
                a = rnd_opnd(64); b = rnd_opnd(64); op = 2'($urandom_range(0, 3));
                cin = 1'($urandom_range(0, 1)); sat = 1'($urandom_range(0, 1));
                p64_in_valid = 1; p64_in_a = a; p64_in_b = b; p64_in_op = op; p64_in_cin = cin; p64_in_sat = sat;
                q64.push_back('{model(64, a, b, op, cin, sat), cyc});
            end else begin
                p32_in_valid = 0; p16_in_valid = 0; p64_in_valid = 0;
            end
            @(negedge clk);
            if (p32_out_valid) begin
                checks++;
                if (q32.size() == 0) begin errors++; $display("FAIL b2b32_unexpected got %h required none", p32_out_s); end
                else begin
                    e = q32.pop_front();
                    if ({p32_out_s, p32_out_cf, p32_out_of, p32_out_zf, p32_out_nf} !== {e.r.s[31:0], e.r.cf, e.r.of, e.r.zf, e.r.nf}
                        || cyc - e.cyc != 4) begin
                        errors++;
                        $display("FAIL b2b32 got %h lat %0d required %h lat 4",
                                 {p32_out_s, p32_out_cf, p32_out_of, p32_out_zf, p32_out_nf}, cyc - e.cyc,
                                 {e.r.s[31:0], e.r.cf, e.r.of, e.r.zf, e.r.nf});
                    end
                end
            end
            if (p16_out_valid) begin
                checks++;
                if (q16.size() == 0) begin errors++; $display("FAIL b2b16_unexpected got %h required none", p16_out_s); end
                else begin
                    e = q16.pop_front();
                    if ({p16_out_s, p16_out_cf, p16_out_of, p16_out_zf, p16_out_nf} !== {e.r.s[15:0], e.r.cf, e.r.of, e.r.zf, e.r.nf}
                        || cyc - e.cyc != 1) begin
                        errors++;
                        $display("FAIL b2b16 got %h lat %0d required %h lat 1",
                                 {p16_out_s, p16_out_cf, p16_out_of, p16_out_zf, p16_out_nf}, cyc - e.cyc,
                                 {e.r.s[15:0], e.r.cf, e.r.of, e.r.zf, e.r.nf});
                    end
                end
            end
            if (p64_out_valid) begin
                checks++;
                if (q64.size() == 0) begin errors++; $display("FAIL b2b64_unexpected got %h required none", p64_out_s); end
                else begin
                    e = q64.pop_front();
                    if ({p64_out_s, p64_out_cf, p64_out_of, p64_out_zf, p64_out_nf} !== {e.r.s, e.r.cf, e.r.of, e.r.zf, e.r.nf}
                        || cyc - e.cyc != 8) begin
                        errors++;
                        $display("FAIL b2b64 got %h lat %0d required %h lat 8",
                                 {p64_out_s, p64_out_cf, p64_out_of, p64_out_zf, p64_out_nf}, cyc - e.cyc,
                                 {e.r.s, e.r.cf, e.r.of, e.r.zf, e.r.nf});
                    end
                end
            end
        end
        checks++;
        if (q32.size() + q16.size() + q64.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain got %0d/%0d/%0d pending required 0", q32.size(), q16.size(), q64.size());
        end
        $display("back-to-back: %0d ops per width streamed", n);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_multiword();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
